// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for a pointer-based FIFO.
// Keeps the read pointer, derives occupancy and empty/almost-empty flags
// from the write pointer, and reports a sticky underflow error.
// All state advances on the falling edge of clk.
module fifo_rd_ctrl #(
  parameter int unsigned R_DATA_WIDTH = 16,
  parameter int unsigned MEM_WIDTH    = 16,
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned AE_THRESH    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_request,
  input  logic                  clr_err,
  input  logic [ADDR_WIDTH:0]   wr_ptr,
  output logic [ADDR_WIDTH:0]   rd_ptr,
  output logic                  rd_en,
  output logic                  rd_valid,
  output logic                  empty_flag,
  output logic                  almost_empty_flag,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  underflow
);

  localparam int unsigned PW      = ADDR_WIDTH + 1;
  localparam int unsigned RD_STEP = R_DATA_WIDTH / MEM_WIDTH;
  localparam logic [PW-1:0] STEP_P = PW'(RD_STEP);

  // Occupancy, flags and read enable; the wrap bit makes a plain
  // modulo subtraction distinguish full from empty.
  always_comb begin
    count             = wr_ptr - rd_ptr;
    empty_flag        = (32'(count) < RD_STEP);
    almost_empty_flag = (32'(count) <= AE_THRESH);
    rd_en             = rd_request & ~empty_flag;
  end

  // Read pointer, data-valid pipeline and sticky underflow (set wins over clear).
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr    <= '0;
      rd_valid  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en)
        rd_ptr <= rd_ptr + STEP_P;
      if (rd_request && empty_flag)
        underflow <= 1'b1;
      else if (clr_err)
        underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed self-checking bench for fifo_rd_ctrl: one default-width instance
// and one instance reading two storage words per request.
module tb_fifo_rd_ctrl;

  logic       clk = 1'b1;
  logic       reset;
  logic       rd_request, clr_err;
  logic [4:0] wr_ptr, rd_ptr, count;
  logic       rd_en, rd_valid, empty_flag, almost_empty_flag, underflow;

  logic       rd_request32, clr_err32;
  logic [4:0] wr_ptr32, rd_ptr32, count32;
  logic       rd_en32, rd_valid32, empty32, ae32, underflow32;

  int checks = 0;
  int errors = 0;

  fifo_rd_ctrl #(.R_DATA_WIDTH(16), .MEM_WIDTH(16), .ADDR_WIDTH(4), .AE_THRESH(2)) dut (
    .clk(clk), .reset(reset), .rd_request(rd_request), .clr_err(clr_err),
    .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .rd_en(rd_en), .rd_valid(rd_valid),
    .empty_flag(empty_flag), .almost_empty_flag(almost_empty_flag),
    .count(count), .underflow(underflow)
  );

  fifo_rd_ctrl #(.R_DATA_WIDTH(32), .MEM_WIDTH(16), .ADDR_WIDTH(4), .AE_THRESH(2)) dut32 (
    .clk(clk), .reset(reset), .rd_request(rd_request32), .clr_err(clr_err32),
    .wr_ptr(wr_ptr32), .rd_ptr(rd_ptr32), .rd_en(rd_en32), .rd_valid(rd_valid32),
    .empty_flag(empty32), .almost_empty_flag(ae32),
    .count(count32), .underflow(underflow32)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for the active (falling) edge, then move 1 time unit past it.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; rd_request = 1'b0; clr_err = 1'b0; wr_ptr = 5'd0;
    rd_request32 = 1'b0; clr_err32 = 1'b0; wr_ptr32 = 5'd0;
    #1;
    chk("rst_rd_ptr", rd_ptr, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty_flag, 1);
    chk("rst_ae", almost_empty_flag, 1);
    chk("rst_rd_en", rd_en, 0);
    tick(); tick();
    reset = 1'b0;

    // Read from an empty FIFO
    rd_request = 1'b1; #1;
    chk("uf_rd_en", rd_en, 0);
    chk("uf_empty", empty_flag, 1);
    tick();
    chk("uf_set", underflow, 1);
    chk("uf_rd_ptr", rd_ptr, 0);
    chk("uf_rd_valid", rd_valid, 0);
    rd_request = 1'b0; clr_err = 1'b1;
    tick();
    chk("uf_clr", underflow, 0);

    // Set beats clear on the same edge
    clr_err = 1'b0; rd_request = 1'b1;
    tick();
    chk("prio_set", underflow, 1);
    clr_err = 1'b1;
    tick();
    chk("prio_both", underflow, 1);
    rd_request = 1'b0;
    tick();
    chk("prio_clr", underflow, 0);
    clr_err = 1'b0;

    // Three words available, request held four edges
    wr_ptr = 5'd3; rd_request = 1'b1; #1;
    chk("r3_count", count, 3);
    chk("r3_ae_above", almost_empty_flag, 0);
    chk("r3_rd_en0", rd_en, 1);
    tick();
    chk("r3_ptr1", rd_ptr, 1);
    chk("r3_valid1", rd_valid, 1);
    chk("r3_ae_at", almost_empty_flag, 1);
    tick();
    chk("r3_ptr2", rd_ptr, 2);
    chk("r3_valid2", rd_valid, 1);
    tick();
    chk("r3_ptr3", rd_ptr, 3);
    chk("r3_valid3", rd_valid, 1);
    chk("r3_empty", empty_flag, 1);
    chk("r3_rd_en3", rd_en, 0);
    chk("r3_uf_none", underflow, 0);
    tick();
    chk("r3_ptr_hold", rd_ptr, 3);
    chk("r3_valid4", rd_valid, 0);
    chk("r3_uf4", underflow, 1);
    rd_request = 1'b0; clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("r3_uf_clr", underflow, 0);

    // Double-width reads: three words hold only one full read
    wr_ptr32 = 5'd3; rd_request32 = 1'b1; #1;
    chk("w32_rd_en", rd_en32, 1);
    chk("w32_count", count32, 3);
    tick();
    chk("w32_ptr", rd_ptr32, 2);
    chk("w32_valid", rd_valid32, 1);
    chk("w32_count1", count32, 1);
    chk("w32_empty", empty32, 1);
    chk("w32_rd_en_off", rd_en32, 0);
    rd_request32 = 1'b0;
    tick();
    chk("w32_valid_off", rd_valid32, 0);
    chk("w32_ptr_hold", rd_ptr32, 2);

    // Wrap: read up to 15, then across the depth boundary
    wr_ptr = 5'd15; rd_request = 1'b1;
    repeat (12) tick();
    chk("wr_ptr15", rd_ptr, 15);
    chk("wr_empty15", empty_flag, 1);
    wr_ptr = 5'd16; #1;
    chk("wr_count1", count, 1);
    chk("wr_rd_en", rd_en, 1);
    tick();
    chk("wr_ptr16", rd_ptr, 5'b10000);
    chk("wr_count0", count, 0);
    chk("wr_empty", empty_flag, 1);
    rd_request = 1'b0; wr_ptr = 5'd17; #1;
    chk("wr_count17", count, 1);
    chk("wr_nonempty", empty_flag, 0);
    chk("wr_uf", underflow, 0);

    // Full FIFO, read with concurrent write
    reset = 1'b1; wr_ptr = 5'd16; wr_ptr32 = 5'd0; rd_request32 = 1'b1; #1;
    chk("full_rst_ptr", rd_ptr, 0);
    tick();
    reset = 1'b0; #1;
    chk("full_count", count, 16);
    chk("full_empty", empty_flag, 0);
    chk("full_ae", almost_empty_flag, 0);
    rd_request = 1'b1; #1;
    chk("full_rd_en", rd_en, 1);
    tick();
    wr_ptr = 5'd17; #1;
    chk("full_ptr", rd_ptr, 1);
    chk("full_count_kept", count, 16);
    chk("full_valid", rd_valid, 1);
    chk("w32_uf", underflow32, 1);

    // Asynchronous reset between edges
    #2;
    reset = 1'b1; #1;
    chk("ar_ptr", rd_ptr, 0);
    chk("ar_valid", rd_valid, 0);
    chk("ar_uf32", underflow32, 0);
    chk("ar_ptr32", rd_ptr32, 0);
    wr_ptr = 5'd0; rd_request = 1'b0; rd_request32 = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_valid", rd_valid, 0);
    chk("post_rst_ptr", rd_ptr, 0);
    chk("post_rst_uf", underflow, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
